usb_burst_streamer: RTL and testbench
=====================================

# usb_burst_streamer

Parametrised burst sender for the USB/SD output path. It replaces the fixed 256-word, 16-bit frame sender with a block that has configurable word width, burst length, lead-in delay and pulse tail. It adds back-pressure from the sink, a read strobe to a first-word-fall-through FIFO, and per-frame burst accounting. It sits between the frame buffer FIFO and the USB/SD write port, clocked by `usb_clk` and cleared by `nframe`.

## Interface
Parameters:
- `DATA_W`, 16: word width.
- `BURST_LEN`, 256: words per burst, minimum 2.
- `LEAD_CYCLES`, 2: idle cycles between `data_pulse` rising and the first write, minimum 0.
- `PULSE_TAIL`, 3: number of final words written with `data_pulse` low. Range 0 to `BURST_LEN`-1.
- `CNT_W`, 16: width of the per-frame burst counter.

Ports:
- `usb_clk`  in  1  the only clock.
- `nframe`  in  1  reset, synchronous and active-high, sampled on `usb_clk` rising edge. Also marks the frame boundary.
- `send_out`  in  1  burst request, level-sensitive, sampled only in IDLE.
- `data_in`  in  `DATA_W`  word from the FWFT FIFO.
- `sink_full`  in  1  sink back-pressure; while high, no word is written.
- `data_rd`  out  1  FIFO read strobe. Combinational: `state==XFER && !sink_full`.
- `USB_DATA`  out  `DATA_W`  registered output word.
- `usb_wr`  out  1  registered write strobe; `USB_DATA` is valid when high.
- `data_pulse`  out  1  burst envelope to the downstream SD writer.
- `busy`  out  1  high in every state except IDLE.
- `burst_done`  out  1  one-cycle pulse after the final word of a burst.
- `burst_cnt`  out  `CNT_W`  bursts completed since the last `nframe`; wraps modulo 2^`CNT_W`.

## Operation
- States:
  - IDLE: `send_out`=1 moves to LEAD (or to XFER if `LEAD_CYCLES`=0) and sets `data_pulse`=1.
  - LEAD: counts `LEAD_CYCLES` cycles, then moves to XFER.
  - XFER: each cycle with `!sink_full` writes one word; the last word moves to DONE.
  - DONE: one cycle with `burst_done`=1 and `burst_cnt`+1, then returns to IDLE.
- There is no stuck power-up state: reset lands in IDLE.
- Writes:
  - On an edge where `data_rd`=1, the block registers `USB_DATA`<=`data_in`, `usb_wr`<=1 and `wcnt`+1.
  - On any other edge, `usb_wr`<=0 and `USB_DATA` holds its value.
- Word counter `wcnt` is $clog2(`BURST_LEN`+1) bits, cleared on IDLE→LEAD/XFER.
- `data_pulse` goes low on the edge at which `wcnt` reaches `BURST_LEN`-`PULSE_TAIL`. If `PULSE_TAIL`=0, it goes low on entry to DONE.
- Boundary conditions:
  - `sink_full` high in XFER stalls `wcnt`, `data_rd` and `usb_wr` indefinitely. `data_pulse` is unaffected.
  - `sink_full` in IDLE or LEAD is ignored.
  - `send_out` held high gives back-to-back bursts separated by exactly DONE plus one IDLE cycle.
  - `send_out` changes during a burst are ignored.
  - `nframe` in any state, including mid-XFER, takes priority over everything. The partial burst is dropped and not counted.
  - `burst_cnt` wrap: 2^`CNT_W`-1 → 0 with no flag.

## Timing
- Reset values at the edge after `nframe`=1:
  - state is IDLE;
  - `USB_DATA`, `usb_wr`, `data_pulse`, `busy`, `burst_done` and `burst_cnt` are all 0;
  - `wcnt` and the lead counter are 0.
- Latency with edge E0 sampling `send_out`=1 in IDLE:
  - `data_pulse`/`busy` high after E0.
  - First `data_rd` in the cycle after E(`LEAD_CYCLES`).
  - First `usb_wr` high after E(`LEAD_CYCLES`+1), with no stalls.
- Unstalled burst: `usb_wr` high for exactly `BURST_LEN` consecutive cycles.
- `burst_done` is high in the cycle after the last `usb_wr` cycle. `busy` falls one cycle later.

## Structure
- Shared package `usb_stream_pkg` holds:
  - the state enum (IDLE, LEAD, XFER, DONE);
  - default parameter constants;
  - a function `cnt_w(n)` = $clog2(n+1).
- One natural sub-module, `burst_counter`: a parametrised up-counter with clear, enable and terminal-count compare. It is instantiated for `wcnt` and for the lead counter.
- Parameter legality is checked with elaboration-time assertions.

## Test plan
- Defaults, `send_out` pulsed once, `sink_full`=0 → `data_pulse` rises after E0; `usb_wr` high on E3..E258; `data_pulse` low for the last 3 words (words 253-255); `burst_done` once; `burst_cnt`=1.
- `sink_full` high for 10 cycles at word 100 → no `usb_wr` or `data_rd` during the stall; `USB_DATA` held; all 256 words still delivered in order with FIFO data 0..255 intact.
- `send_out` held high for three bursts → three `burst_done` pulses; the gap between bursts is 2 cycles of DONE/IDLE plus `LEAD_CYCLES`; `burst_cnt`=3.
- `nframe` asserted at word 50 → outputs and `burst_cnt` are 0 on the next edge; a new `send_out` starts a fresh burst from word 0.
- `BURST_LEN`=8, `LEAD_CYCLES`=0, `PULSE_TAIL`=0, `DATA_W`=32 → first `usb_wr` after E1; `data_pulse` high through all 8 words and low in DONE.
- `CNT_W`=2 with 5 bursts → `burst_cnt` sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/usb_burst_streamer_pkg.sv
// usb_stream_pkg: streamer FSM states, default parameters and counter-width helper
package usb_stream_pkg;
  typedef enum logic [1:0] {IDLE, LEAD, XFER, DONE} state_t;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_BURST_LEN = 256;
  localparam int unsigned DEF_LEAD_CYCLES = 2;
  localparam int unsigned DEF_PULSE_TAIL = 3;
  localparam int unsigned DEF_CNT_W = 16;
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/usb_burst_streamer_if.sv
// usb_burst_streamer_if: request/FIFO/back-pressure inputs and write/envelope/status outputs of the streamer
interface usb_burst_streamer_if #(
  parameter int unsigned DATA_W = usb_stream_pkg::DEF_DATA_W,
  parameter int unsigned CNT_W = usb_stream_pkg::DEF_CNT_W
);
  logic send_out, sink_full, data_rd, usb_wr, data_pulse, busy, burst_done;
  logic [DATA_W-1:0] data_in, USB_DATA;
  logic [CNT_W-1:0] burst_cnt;
  modport master (
    output send_out, data_in, sink_full,
    input data_rd, USB_DATA, usb_wr, data_pulse, busy, burst_done, burst_cnt
  );
  modport slave (
    input send_out, data_in, sink_full,
    output data_rd, USB_DATA, usb_wr, data_pulse, busy, burst_done, burst_cnt
  );
endinterface

// File: rtl/usb_burst_streamer_counter.sv
// burst_counter: up-counter with sync clear, enable and terminal-count compare (clk, rst, clr, en -> cnt, tc)
module burst_counter #(
  parameter int unsigned W = 8,
  parameter int unsigned TC = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : en ? cnt + W'(1) : cnt;
  assign tc = cnt == W'(TC);
endmodule

// File: rtl/usb_burst_streamer.sv
// usb_burst_streamer: FWFT FIFO to USB/SD burst sender; usb_clk, nframe (sync reset/frame mark) and bus (send_out, data_in, sink_full in; data_rd, USB_DATA, usb_wr, data_pulse, busy, burst_done, burst_cnt out)
module usb_burst_streamer
  import usb_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN,
  parameter int unsigned LEAD_CYCLES = DEF_LEAD_CYCLES,
  parameter int unsigned PULSE_TAIL = DEF_PULSE_TAIL,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input logic usb_clk,
  input logic nframe,
  usb_burst_streamer_if.slave bus
);
  localparam int unsigned WW = cnt_w(BURST_LEN);
  localparam int unsigned LW = LEAD_CYCLES > 0 ? cnt_w(LEAD_CYCLES) : 1;
  localparam int unsigned LTC = LEAD_CYCLES > 0 ? LEAD_CYCLES - 1 : 0;
  if (BURST_LEN < 2) begin : g_bad_len
    $error("BURST_LEN must be at least 2");
  end
  if (PULSE_TAIL >= BURST_LEN) begin : g_bad_tail
    $error("PULSE_TAIL must be below BURST_LEN");
  end
  if (DATA_W == 0 || CNT_W == 0) begin : g_bad_width
    $error("DATA_W and CNT_W must be non-zero");
  end
  state_t state;
  logic rd, w_tc, l_tc;
  logic [WW-1:0] wcnt;
  logic [LW-1:0] lcnt;
  assign rd = state == XFER && !bus.sink_full;
  assign bus.data_rd = rd;
  burst_counter #(.W(WW), .TC(BURST_LEN - 1)) u_wcnt (
    .clk(usb_clk), .rst(nframe), .clr(state == IDLE && bus.send_out), .en(rd), .cnt(wcnt), .tc(w_tc)
  );
  burst_counter #(.W(LW), .TC(LTC)) u_lcnt (
    .clk(usb_clk), .rst(nframe), .clr(state == IDLE), .en(state == LEAD), .cnt(lcnt), .tc(l_tc)
  );
  // the lead counter stops one past its terminal value, on the edge that leaves LEAD
  assert property (@(posedge usb_clk) disable iff (nframe) lcnt <= LW'(LEAD_CYCLES));
  always_ff @(posedge usb_clk) begin
    if (nframe) begin
      state <= IDLE;
      bus.USB_DATA <= '0;
      bus.usb_wr <= 1'b0;
      bus.data_pulse <= 1'b0;
      bus.busy <= 1'b0;
      bus.burst_done <= 1'b0;
      bus.burst_cnt <= '0;
    end else begin
      bus.usb_wr <= rd;
      bus.burst_done <= 1'b0;
      if (rd) bus.USB_DATA <= bus.data_in;
      case (state)
        IDLE: begin
          // busy stays up through the burst_done cycle and drops only when no new burst starts
          bus.busy <= bus.send_out;
          if (bus.send_out) begin
            state <= LEAD_CYCLES == 0 ? XFER : LEAD;
            bus.data_pulse <= 1'b1;
          end
        end
        LEAD: if (l_tc) state <= XFER;
        XFER: if (rd) begin
          // envelope drops as wcnt reaches BURST_LEN-PULSE_TAIL; with no tail that is the last write
          if (wcnt == WW'(BURST_LEN - PULSE_TAIL - 1)) bus.data_pulse <= 1'b0;
          if (w_tc) state <= DONE;
        end
        default: begin
          state <= IDLE;
          bus.burst_done <= 1'b1;
          bus.burst_cnt <= bus.burst_cnt + CNT_W'(1);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_usb_burst_streamer.sv
// tb_usb_burst_streamer: scoreboard bench for a default streamer and a short 32-bit wrap-prone one
module tb_usb_burst_streamer;
  typedef struct {
    logic [31:0] d;
    logic        p;
  } exp_t;
  logic clk = 1'b0;
  logic nframe = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int rda = 0;
  int rdb = 0;
  exp_t qa[$];
  exp_t qb[$];
  int qca[$];
  int qcb[$];
  logic a_rp = 1'b0, b_rp = 1'b0, a_pw = 1'b0, b_pw = 1'b0;
  always #5 clk = ~clk;
  usb_burst_streamer_if #(.DATA_W(16), .CNT_W(16)) a();
  usb_burst_streamer_if #(.DATA_W(32), .CNT_W(2)) b();
  usb_burst_streamer #(.DATA_W(16), .BURST_LEN(256), .LEAD_CYCLES(2), .PULSE_TAIL(3), .CNT_W(16)) dut_a (
    .usb_clk(clk), .nframe(nframe), .bus(a)
  );
  usb_burst_streamer #(.DATA_W(32), .BURST_LEN(8), .LEAD_CYCLES(0), .PULSE_TAIL(0), .CNT_W(2)) dut_b (
    .usb_clk(clk), .nframe(nframe), .bus(b)
  );
  function automatic logic [31:0] fb(input int x);
    return {x[15:0], ~x[15:0]};
  endfunction
  function automatic exp_t mk(input logic [31:0] d, input logic p);
    exp_t e;
    e.d = d;
    e.p = p;
    return e;
  endfunction
  // FWFT FIFO models: the head word is a function of how many words have been popped
  assign a.data_in = 16'(rda);
  assign b.data_in = fb(rdb);
  always @(posedge clk) begin
    if (a.data_rd) rda <= rda + 1;
    if (b.data_rd) rdb <= rdb + 1;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (a.usb_wr) begin
      if (qa.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL a_unexpected_wr: got %0h expected no write", a.USB_DATA);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_data", a.USB_DATA, e.d);
        chk("a_pulse_at_read", a_rp, e.p);
      end
    end
    if (a.data_rd) a_rp = a.data_pulse;
    if (a.burst_done) begin
      chk("a_done_after_wr", a_pw, 1);
      if (qca.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL a_unexpected_done: got burst_cnt %0d expected no burst_done", a.burst_cnt);
      end else chk("a_burst_cnt", a.burst_cnt, qca.pop_front());
    end
    a_pw = a.usb_wr;
  end
  always @(negedge clk) begin
    if (b.usb_wr) begin
      if (qb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL b_unexpected_wr: got %0h expected no write", b.USB_DATA);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_data", b.USB_DATA, e.d);
        chk("b_pulse_at_read", b_rp, e.p);
      end
    end
    if (b.data_rd) b_rp = b.data_pulse;
    if (b.burst_done) begin
      chk("b_done_after_wr", b_pw, 1);
      if (qcb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL b_unexpected_done: got burst_cnt %0d expected no burst_done", b.burst_cnt);
      end else chk("b_burst_cnt", b.burst_cnt, qcb.pop_front());
    end
    b_pw = b.usb_wr;
  end
  task automatic chk_zero_a(input string nm);
    chk({nm, "_usb_wr"}, a.usb_wr, 0);
    chk({nm, "_usb_data"}, a.USB_DATA, 0);
    chk({nm, "_pulse"}, a.data_pulse, 0);
    chk({nm, "_busy"}, a.busy, 0);
    chk({nm, "_done"}, a.burst_done, 0);
    chk({nm, "_cnt"}, a.burst_cnt, 0);
    chk({nm, "_rd"}, a.data_rd, 0);
  endtask
  task automatic run_a(input int cnt);
    int n, m, base;
    base = rda;
    for (int i = 0; i < 256; i++) qa.push_back(mk(32'(16'(base + i)), i < 253));
    qca.push_back(cnt);
    a.send_out = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a.send_out = 1'b0;
    chk("a_pulse_rise", a.data_pulse, 1);
    chk("a_busy_rise", a.busy, 1);
    n = 0;
    while (!a.usb_wr && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("a_first_wr_edge", n, 3);
    m = 0;
    while (a.usb_wr && m < 300) begin
      m++;
      @(negedge clk);
    end
    chk("a_wr_run", m, 256);
    chk("a_done_pulse", a.burst_done, 1);
    chk("a_busy_in_done", a.busy, 1);
    chk("a_cnt_after", a.burst_cnt, cnt);
    @(negedge clk);
    chk("a_done_clear", a.burst_done, 0);
    chk("a_busy_fall", a.busy, 0);
    chk("a_q_empty", qa.size(), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end
  initial begin
    int n, m, base, gap, rises, dones;
    logic prev;
    a.send_out = 1'b0;
    a.sink_full = 1'b0;
    b.send_out = 1'b0;
    b.sink_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero_a("a_reset");
    chk("b_reset_usb_wr", b.usb_wr, 0);
    chk("b_reset_usb_data", b.USB_DATA, 0);
    chk("b_reset_busy", b.busy, 0);
    chk("b_reset_cnt", b.burst_cnt, 0);
    nframe = 1'b0;
    run_a(1);
    base = rda;
    for (int i = 0; i < 256; i++) qa.push_back(mk(32'(16'(base + i)), i < 253));
    qca.push_back(2);
    a.send_out = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a.send_out = 1'b0;
    n = 0;
    m = 0;
    while (n < 100 && m < 400) begin
      @(negedge clk);
      m++;
      if (a.usb_wr) n++;
    end
    chk("a_reach_word_100", n, 100);
    #1 a.sink_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("a_stall_usb_wr", a.usb_wr, 0);
      chk("a_stall_data_rd", a.data_rd, 0);
      chk("a_stall_hold", a.USB_DATA, 16'(base + 99));
      chk("a_stall_pulse", a.data_pulse, 1);
    end
    #1 a.sink_full = 1'b0;
    n = 0;
    while (!a.burst_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("a_stall_done", a.burst_done, 1);
    @(negedge clk);
    chk("a_stall_q_empty", qa.size(), 0);
    chk("a_stall_cnt", a.burst_cnt, 2);
    base = rda;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 256; i++) qa.push_back(mk(32'(16'(base + 256 * k + i)), i < 253));
      qca.push_back(3 + k);
    end
    a.send_out = 1'b1;
    rises = 0;
    dones = 0;
    gap = 0;
    prev = 1'b0;
    for (int c = 0; c < 1200 && dones < 3; c++) begin
      @(negedge clk);
      if (a.usb_wr && !prev) begin
        rises++;
        if (rises > 1) chk("a_b2b_gap", gap, 4);
        if (rises == 3) a.send_out = 1'b0;
      end
      gap = a.usb_wr ? 0 : gap + 1;
      if (a.burst_done) dones++;
      prev = a.usb_wr;
    end
    chk("a_b2b_dones", dones, 3);
    @(negedge clk);
    chk("a_b2b_cnt", a.burst_cnt, 5);
    chk("a_b2b_idle", a.busy, 0);
    chk("a_b2b_q_empty", qa.size(), 0);
    base = rda;
    for (int i = 0; i < 256; i++) qa.push_back(mk(32'(16'(base + i)), i < 253));
    a.send_out = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a.send_out = 1'b0;
    n = 0;
    m = 0;
    while (n < 50 && m < 400) begin
      @(negedge clk);
      m++;
      if (a.usb_wr) n++;
    end
    chk("a_reach_word_50", n, 50);
    #1 nframe = 1'b1;
    @(negedge clk);
    qa.delete();
    chk_zero_a("a_midburst_reset");
    #1 nframe = 1'b0;
    run_a(1);
    for (int k = 0; k < 5; k++) begin
      base = rdb;
      for (int i = 0; i < 8; i++) qb.push_back(mk(fb(base + i), 1'b1));
      qcb.push_back((k + 1) % 4);
      b.send_out = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b.send_out = 1'b0;
      chk("b_pulse_rise", b.data_pulse, 1);
      n = 0;
      while (!b.usb_wr && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("b_first_wr_edge", n, 1);
      m = 0;
      while (b.usb_wr && m < 20) begin
        if (m == 7) chk("b_pulse_low_in_done", b.data_pulse, 0);
        m++;
        @(negedge clk);
      end
      chk("b_wr_run", m, 8);
      chk("b_done_pulse", b.burst_done, 1);
      chk("b_cnt_wrap", b.burst_cnt, (k + 1) % 4);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("a_cnt_q_empty", qca.size(), 0);
    chk("b_q_empty", qb.size() + qcb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
